// File: rtl/fifo_rd_fwft_stage_if.sv
// Handshake bundle between the read pointer block, the FWFT output stage and its consumer.
// The master modport is the output stage side; slave is the surrounding environment.
interface fifo_rd_fwft_stage_if #(
  parameter int data_width = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [data_width-1:0] fifo_rd_data;
  logic [data_width-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  flush;
  logic [1:0]            occupancy;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  dout_ready,
    input  flush,
    output fifo_rd_en,
    output dout,
    output dout_valid,
    output occupancy
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output dout_ready,
    output flush,
    input  fifo_rd_en,
    input  dout,
    input  dout_valid,
    input  occupancy
  );
endinterface

// File: rtl/fifo_rd_fwft_stage.sv
// First-word-fall-through output stage for the async FIFO read side: turns the
// empty/rd_en pop interface with 1-cycle read latency into a registered valid/ready stream.
//
// state | meaning
// B0    | output buffer empty, dout_valid low
// B1    | head register holds the next word
// B2    | head and second registers both hold words, no further pops issued
module fifo_rd_fwft_stage #(
  parameter int data_width = 8,
  parameter int buf_depth  = 2
) (
  input  logic                  rdclk,
  input  logic                  rd_rst_n,
  fifo_rd_fwft_stage_if.master  bus
);

  if (buf_depth != 2) begin : g_bad_depth
    $error("fifo_rd_fwft_stage: buf_depth must be 2");
  end

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } buf_state_e;

  buf_state_e            state_q, state_d;
  logic                  inflight_q;
  logic [data_width-1:0] head_q, second_q;
  logic                  valid;
  logic                  deq;
  logic                  arrive;
  logic                  rd_en;
  logic [2:0]            pending;
  logic                  head_from_rd, head_from_second, second_from_rd;

  assign valid   = (state_q != B0);
  assign deq     = valid & bus.dout_ready;
  assign arrive  = inflight_q & ~bus.flush;
  assign pending = {1'b0, state_q} + {2'b00, inflight_q};
  // Gated by reset so the pop request is low while the pointer block is held in reset.
  assign rd_en   = rd_rst_n & ~bus.fifo_empty & ~bus.flush &
                   (pending < (3'd2 + {2'b00, deq}));

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= B0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = B0;
    end else begin
      case (state_q)
        B0: if (arrive) state_d = B1;
        B1: begin
          if (arrive && !deq)      state_d = B2;
          else if (!arrive && deq) state_d = B0;
        end
        B2: if (deq && !arrive) state_d = B1;
        default: state_d = B0;
      endcase
    end
  end

  always_comb begin
    head_from_rd     = 1'b0;
    head_from_second = 1'b0;
    second_from_rd   = 1'b0;
    case (state_q)
      B0: head_from_rd = arrive;
      B1: begin
        head_from_rd   = arrive & deq;
        second_from_rd = arrive & ~deq;
      end
      B2: begin
        head_from_second = deq;
        second_from_rd   = deq & arrive;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      head_q   <= '0;
      second_q <= '0;
    end else if (bus.flush) begin
      head_q   <= '0;
      second_q <= '0;
    end else begin
      if (head_from_rd)          head_q <= bus.fifo_rd_data;
      else if (head_from_second) head_q <= second_q;
      if (second_from_rd)        second_q <= bus.fifo_rd_data;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.dout       = head_q;
  assign bus.dout_valid = valid;
  assign bus.occupancy  = state_q;

  // Pop gating keeps occupancy + inflight <= 2, so a full buffer never sees an arrival without a dequeue.
  a_no_overflow: assert property (@(posedge rdclk) disable iff (!rd_rst_n)
    !(state_q == B2 && inflight_q && !deq));

  a_no_pop_when_empty: assert property (@(posedge rdclk) disable iff (!rd_rst_n)
    !(rd_en && bus.fifo_empty));

endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// Directed bench for fifo_rd_fwft_stage: a small array-backed source models the read
// pointer block and memory (data returned the cycle after a sampled pop).
module tb_fifo_rd_fwft_stage;

  logic rdclk;
  logic rd_rst_n;

  fifo_rd_fwft_stage_if #(.data_width(8)) bus ();

  fifo_rd_fwft_stage #(.data_width(8), .buf_depth(2)) dut (
    .rdclk    (rdclk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  int         n_cmp;
  int         n_err;
  logic [7:0] src [0:31];
  int         src_len;
  int         ptr;
  logic       hold_empty;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    bus.fifo_empty = hold_empty || (ptr >= src_len);
  endtask

  // One rdclk cycle: a pop seen before the edge returns its word right after the edge.
  task automatic tick();
    logic pop;
    pop = bus.fifo_rd_en;
    @(posedge rdclk);
    #1;
    if (pop) begin
      bus.fifo_rd_data = src[ptr[4:0]];
      ptr++;
    end
    upd_empty();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    src_len = 0;
    ptr = 0;
    hold_empty = 1'b1;
    rd_rst_n = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = 8'hEE;
    bus.dout_ready = 1'b0;
    bus.flush = 1'b0;

    // 1: reset with empty source
    #3;
    chk("t1_rst_rd_en", 16'(bus.fifo_rd_en), 16'(0));
    chk("t1_rst_valid", 16'(bus.dout_valid), 16'(0));
    chk("t1_rst_occ",   16'(bus.occupancy),  16'(0));
    chk("t1_rst_dout",  16'(bus.dout),       16'(0));
    tick();
    rd_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t1_idle_rd_en", 16'(bus.fifo_rd_en), 16'(0));
      chk("t1_idle_valid", 16'(bus.dout_valid), 16'(0));
    end

    // 2: single word 0xA5, two-cycle latency
    src[0] = 8'hA5;
    src_len = 1;
    ptr = 0;
    hold_empty = 1'b0;
    bus.dout_ready = 1'b1;
    upd_empty();
    #1;
    chk("t2_c0_rd_en", 16'(bus.fifo_rd_en), 16'(1));
    tick();
    chk("t2_c1_valid", 16'(bus.dout_valid), 16'(0));
    chk("t2_c1_rd_en", 16'(bus.fifo_rd_en), 16'(0));
    tick();
    chk("t2_c2_valid", 16'(bus.dout_valid), 16'(1));
    chk("t2_c2_dout",  16'(bus.dout),       16'(8'hA5));
    chk("t2_c2_occ",   16'(bus.occupancy),  16'(1));
    tick();
    chk("t2_c3_valid", 16'(bus.dout_valid), 16'(0));

    // 3: 16-word stream at full rate
    for (int i = 0; i < 16; i++) src[i[4:0]] = 8'(i + 1);
    src_len = 16;
    ptr = 0;
    upd_empty();
    #1;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t3_valid", 16'(bus.dout_valid), 16'(1));
      chk("t3_dout",  16'(bus.dout),       16'(i + 1));
      tick();
    end
    chk("t3_end_valid", 16'(bus.dout_valid), 16'(0));
    chk("t3_end_occ",   16'(bus.occupancy),  16'(0));

    // 4: consumer stall fills the buffer, then drains in order
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) src[i[4:0]] = 8'(8'h20 + i);
    src_len = 8;
    ptr = 0;
    upd_empty();
    #1;
    tick();
    tick();
    tick();
    chk("t4_full_occ",   16'(bus.occupancy),  16'(2));
    chk("t4_full_rd_en", 16'(bus.fifo_rd_en), 16'(0));
    chk("t4_full_dout",  16'(bus.dout),       16'(8'h20));
    tick();
    tick();
    chk("t4_hold_occ",   16'(bus.occupancy),  16'(2));
    chk("t4_hold_rd_en", 16'(bus.fifo_rd_en), 16'(0));
    chk("t4_hold_dout",  16'(bus.dout),       16'(8'h20));
    chk("t4_hold_valid", 16'(bus.dout_valid), 16'(1));
    chk("t4_hold_ptr",   16'(ptr),            16'(2));
    bus.dout_ready = 1'b1;
    #1;
    chk("t4_deq_rd_en", 16'(bus.fifo_rd_en), 16'(1));
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_valid", 16'(bus.dout_valid), 16'(1));
      chk("t4_drain_dout",  16'(bus.dout),       16'(8'h20 + i));
      tick();
    end
    chk("t4_end_valid", 16'(bus.dout_valid), 16'(0));
    chk("t4_end_occ",   16'(bus.occupancy),  16'(0));

    // 5: flush with a word buffered and one in flight, then with the buffer full
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) src[i[4:0]] = 8'(8'h30 + i);
    src_len = 8;
    ptr = 0;
    upd_empty();
    #1;
    tick();
    tick();
    chk("t5_pre_occ", 16'(bus.occupancy), 16'(1));
    bus.flush = 1'b1;
    #1;
    chk("t5_flush_rd_en", 16'(bus.fifo_rd_en), 16'(0));
    tick();
    bus.flush = 1'b0;
    #1;
    chk("t5_post_valid", 16'(bus.dout_valid), 16'(0));
    chk("t5_post_occ",   16'(bus.occupancy),  16'(0));
    chk("t5_post_rd_en", 16'(bus.fifo_rd_en), 16'(1));
    tick();
    tick();
    chk("t5_next_valid", 16'(bus.dout_valid), 16'(1));
    chk("t5_next_dout",  16'(bus.dout),       16'(8'h32));
    tick();
    chk("t5_full_occ",  16'(bus.occupancy), 16'(2));
    chk("t5_full_dout", 16'(bus.dout),      16'(8'h32));
    bus.flush = 1'b1;
    #1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("t5_fl2_valid", 16'(bus.dout_valid), 16'(0));
    chk("t5_fl2_occ",   16'(bus.occupancy),  16'(0));
    tick();
    tick();
    chk("t5_after_valid", 16'(bus.dout_valid), 16'(1));
    chk("t5_after_dout",  16'(bus.dout),       16'(8'h34));

    // 6: asynchronous reset mid-stream, then a clean restart
    bus.dout_ready = 1'b1;
    #1;
    tick();
    chk("t6_pre_dout", 16'(bus.dout), 16'(8'h35));
    #2;
    rd_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 16'(bus.dout_valid), 16'(0));
    chk("t6_rst_occ",   16'(bus.occupancy),  16'(0));
    chk("t6_rst_dout",  16'(bus.dout),       16'(0));
    chk("t6_rst_rd_en", 16'(bus.fifo_rd_en), 16'(0));
    for (int i = 0; i < 8; i++) src[i[4:0]] = 8'(8'h50 + i);
    src_len = 8;
    ptr = 0;
    upd_empty();
    tick();
    rd_rst_n = 1'b1;
    #1;
    chk("t6_rel_rd_en", 16'(bus.fifo_rd_en), 16'(1));
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t6_valid", 16'(bus.dout_valid), 16'(1));
      chk("t6_dout",  16'(bus.dout),       16'(8'h50 + i));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
